gpio_pad_ctrl_chain: RTL

- Per-pad configuration and control stage that sits directly upstream of sky130_ef_io__gpiov2_pad.
- Holds the pad mode bits in a serially loaded configuration register and muxes management versus user signals onto the pad OUT and OE_N pins.
- Synchronises the pad IN return path.
- Instances daisy-chain their serial ports around the padframe.

---
 rtl/gpio_pad_ctrl_pkg.sv | 35 +++
 rtl/gpio_pad_sync2.sv | 23 ++
 rtl/gpio_pad_ctrl_chain.sv | 113 +++++++++++
 3 files changed

// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared definitions for the GPIO pad control chain: cfg bit map,
// default configuration and the pad drive-mode encoding.
package gpio_pad_ctrl_pkg;

    // Bit positions inside the per-pad configuration word
    localparam int CFG_MGMT_ENA    = 0;
    localparam int CFG_HLD_OVR     = 1;
    localparam int CFG_INP_DIS     = 2;
    localparam int CFG_IB_MODE_SEL = 3;
    localparam int CFG_ANALOG_EN   = 4;
    localparam int CFG_ANALOG_SEL  = 5;
    localparam int CFG_ANALOG_POL  = 6;
    localparam int CFG_SLOW        = 7;
    localparam int CFG_VTRIP_SEL   = 8;
    localparam int CFG_OE_OVR      = 9;
    localparam int CFG_DM_LSB      = 10;
    localparam int CFG_DM_MSB      = 12;

    localparam int          CFG_WIDTH_DEF   = 13;
    // mgmt_ena=1, hld_ovr=1, dm=3'b110 (strong push-pull)
    localparam logic [12:0] DEFAULT_CFG_DEF = 13'h1803;

    // Pad DM[2:0] drive-mode codes
    typedef enum logic [2:0] {
        DM_ANALOG      = 3'b000,
        DM_INPUT_ONLY  = 3'b001,
        DM_WEAK_PULL   = 3'b010,
        DM_OD_LOW      = 3'b011,
        DM_OD_HIGH     = 3'b100,
        DM_STRONG_OD   = 3'b101,
        DM_STRONG      = 3'b110,
        DM_WEAK_STRONG = 3'b111
    } pad_dm_t;

endpackage

// File: rtl/gpio_pad_sync2.sv
// Two-flop synchroniser for an asynchronous pad return signal.
// Both stages clear to 0 on a synchronous active-low reset.
module gpio_pad_sync2 (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic s1;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl_chain.sv
// Per-pad configuration and control stage in front of the GPIOv2 pad.
// A serially loaded shift register (daisy-chained pad to pad) is copied
// into the live cfg register on ser_load; cfg drives the pad mode pins
// and selects management or user ownership of OUT/OE_N and IN.
// Optional build macro GPIO_PAD_CTRL_READBACK_EN adds cfg_rdata and a
// ser_readback strobe that copies cfg into the shift register so the
// live configuration can be streamed back out of the chain.
module gpio_pad_ctrl_chain
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int                   CFG_WIDTH   = CFG_WIDTH_DEF,
    parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG = CFG_WIDTH'(DEFAULT_CFG_DEF)
) (
    input  logic                 clock,
    input  logic                 resetn,
`ifdef GPIO_PAD_CTRL_READBACK_EN
    input  logic                 ser_readback,
    output logic [CFG_WIDTH-1:0] cfg_rdata,
`endif
    input  logic                 ser_en,
    input  logic                 ser_data_in,
    input  logic                 ser_load,
    output logic                 ser_data_out,
    input  logic                 mgmt_out,
    input  logic                 mgmt_oeb,
    output logic                 mgmt_in,
    input  logic                 user_out,
    input  logic                 user_oeb,
    output logic                 user_in,
    input  logic                 pad_in,
    output logic                 pad_out,
    output logic                 pad_oe_n,
    output logic [2:0]           pad_dm,
    output logic                 pad_inp_dis,
    output logic                 pad_ib_mode_sel,
    output logic                 pad_vtrip_sel,
    output logic                 pad_slow,
    output logic                 pad_hld_ovr,
    output logic                 pad_analog_en,
    output logic                 pad_analog_sel,
    output logic                 pad_analog_pol
);

    logic [CFG_WIDTH-1:0] shift_reg;
    logic [CFG_WIDTH-1:0] cfg;
    logic                 in_s2;
    logic                 mgmt_ena;
    logic                 oe_ovr;
    pad_dm_t              dm;

    // Serial chain: shift on ser_en; output bit is registered so the
    // next pad sees a clean flop-to-flop path around the padframe.
    // Readback only applies while the chain is idle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            shift_reg    <= '0;
            ser_data_out <= 1'b0;
        end else if (ser_en) begin
            shift_reg    <= {shift_reg[CFG_WIDTH-2:0], ser_data_in};
            ser_data_out <= shift_reg[CFG_WIDTH-1];
        end
`ifdef GPIO_PAD_CTRL_READBACK_EN
        else if (ser_readback) begin
            shift_reg <= cfg;
        end
`endif
    end

    // Live configuration; samples the pre-shift shift_reg so a load
    // coinciding with a strobe (or a readback swap) takes the old word.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cfg <= DEFAULT_CFG;
        end else if (ser_load) begin
            cfg <= shift_reg;
        end
    end

`ifdef GPIO_PAD_CTRL_READBACK_EN
    assign cfg_rdata = cfg;
`endif

    gpio_pad_sync2 u_in_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (pad_in),
        .q      (in_s2)
    );

    assign mgmt_ena = cfg[CFG_MGMT_ENA];
    assign oe_ovr   = cfg[CFG_OE_OVR];
    assign dm       = pad_dm_t'(cfg[CFG_DM_MSB:CFG_DM_LSB]);

    // Pad mode pins are straight decodes of registered cfg bits
    assign pad_dm          = dm;
    assign pad_hld_ovr     = cfg[CFG_HLD_OVR];
    assign pad_inp_dis     = cfg[CFG_INP_DIS];
    assign pad_ib_mode_sel = cfg[CFG_IB_MODE_SEL];
    assign pad_analog_en   = cfg[CFG_ANALOG_EN];
    assign pad_analog_sel  = cfg[CFG_ANALOG_SEL];
    assign pad_analog_pol  = cfg[CFG_ANALOG_POL];
    assign pad_slow        = cfg[CFG_SLOW];
    assign pad_vtrip_sel   = cfg[CFG_VTRIP_SEL];

    // Ownership mux; oe_ovr forces the driver off regardless of owner
    assign pad_out  = mgmt_ena ? mgmt_out : user_out;
    assign pad_oe_n = (mgmt_ena ? mgmt_oeb : user_oeb) | oe_ovr;

    // Only the owning side sees the pad input, the other reads 0
    assign mgmt_in = mgmt_ena & in_s2;
    assign user_in = ~mgmt_ena & in_s2;

endmodule
